// File: rtl/flop_arb_pkg.sv
// Shared types, default sizes and helpers for the flop bank write arbiter.
package flop_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Round-robin successor of a requester index, wrapping at nreq.
    function automatic int unsigned next_ptr(input int unsigned id, input int unsigned nreq);
        return (id + 1 >= nreq) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/flop_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted valid at or after ptr, wrapping circularly.
module rr_pick
    import flop_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);

    logic [IDW-1:0] cand;

    // NOTE: every output gets a default before the search loop so no path leaves a latch.
    always_comb begin
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!any_valid && valid[cand]) begin
                any_valid = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flop_bank_arbiter.sv
// Round-robin write scheduler with grant lock in front of a small register bank.
// Optional lock timeout enabled by defining ARB_TIMEOUT_EN.
module flop_bank_arbiter
    import flop_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDRW    = 2,
    parameter int MAX_LOCK = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDRW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     grant_valid,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    input  logic [ADDRW-1:0]         rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int IDW = $clog2(NREQ);

    if (MAX_LOCK < 1 || (1 << ADDRW) < DEPTH) begin : g_param_check
        $error("flop_bank_arbiter: illegal MAX_LOCK/ADDRW/DEPTH combination");
    end

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];

    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  eligible;
    logic             sel_lock;
    logic [ADDRW-1:0] w_addr;
    logic [WIDTH-1:0] w_data;
    logic             lock_timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(MAX_LOCK + 1);
    logic [CNTW-1:0] lock_cnt_q, lock_cnt_d;

    assign lock_timeout = (lock_cnt_q == CNTW'(MAX_LOCK - 1));
`else
    assign lock_timeout = 1'b0;
`endif

    // While locked only the owner may compete, so the picker finds it regardless of rr_ptr.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        eligible          = (state_q == LOCKED) ? (req_valid & owner_oh) : req_valid;
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid     (eligible),
        .ptr       (rr_ptr_q),
        .gnt       (req_ready),
        .idx       (grant_id),
        .any_valid (grant_valid)
    );

    always_comb begin
        sel_lock = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_lock = req_lock[i];
                w_addr   = req_addr[i*ADDRW +: ADDRW];
                w_data   = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
`ifdef ARB_TIMEOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (sel_lock) begin
                        state_d = LOCKED;
                        owner_d = grant_id;
`ifdef ARB_TIMEOUT_EN
                        lock_cnt_d = '0;
`endif
                    end else begin
                        rr_ptr_d = IDW'(next_ptr(int'(grant_id), NREQ));
                    end
                end
            end
            LOCKED: begin
`ifdef ARB_TIMEOUT_EN
                lock_cnt_d = lock_cnt_q + 1'b1;
`endif
                if ((grant_valid && !sel_lock) || lock_timeout) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDW'(next_ptr(int'(owner_q), NREQ));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range addresses still take the grant but leave the bank untouched.
    always_comb begin
        bank_d = bank_q;
        if (grant_valid && (int'(w_addr) < DEPTH)) begin
            bank_d[w_addr] = w_data;
        end
    end

    // NOTE: the bank is plain flops, so it is cleared on reset like every other state bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            bank_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            bank_q   <= bank_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign busy    = (state_q == LOCKED);
    assign rd_data = (int'(rd_addr) < DEPTH) ? bank_q[rd_addr] : '0;

endmodule
